// File: rtl/pcie_tx_rr_merge.sv
// Packet-atomic round-robin merge of NUM_PORTS PCIe SS TX AXI-S streams onto one
// host-bound stream through a single registered output stage.
module pcie_tx_rr_merge #(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned TDATA_W    = 512,
    parameter int unsigned TUSER_W    = 10,
    parameter int unsigned PORT_IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    // Per-source TX streams, port i occupies slice i of each flattened vector
    input  logic [NUM_PORTS-1:0]            i_tx_tvalid,
    output logic [NUM_PORTS-1:0]            i_tx_tready,
    input  logic [NUM_PORTS*TDATA_W-1:0]    i_tx_tdata,
    input  logic [NUM_PORTS*TDATA_W/8-1:0]  i_tx_tkeep,
    input  logic [NUM_PORTS-1:0]            i_tx_tlast,
    input  logic [NUM_PORTS*TUSER_W-1:0]    i_tx_tuser_vendor,
    output logic                            o_tx_tvalid,
    input  logic                            o_tx_tready,
    output logic [TDATA_W-1:0]              o_tx_tdata,
    output logic [TDATA_W/8-1:0]            o_tx_tkeep,
    output logic                            o_tx_tlast,
    output logic [TUSER_W-1:0]              o_tx_tuser_vendor,
    output logic [PORT_IDX_W-1:0]           o_active_port,
    output logic                            o_locked
);

    localparam int unsigned KEEP_W = TDATA_W / 8;

    localparam logic [0:0] StUnlocked = 1'b0;
    localparam logic [0:0] StLocked   = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [PORT_IDX_W-1:0] lock_port_q, lock_port_d;
    logic [PORT_IDX_W-1:0] last_grant_q, last_grant_d;
    logic                  tvalid_q, tvalid_d;
    logic [TDATA_W-1:0]    tdata_q, tdata_d;
    logic [KEEP_W-1:0]     tkeep_q, tkeep_d;
    logic                  tlast_q, tlast_d;
    logic [TUSER_W-1:0]    tuser_q, tuser_d;

    logic [PORT_IDX_W-1:0] sel;
    logic                  have_sel;
    int                    cand;
    logic [PORT_IDX_W-1:0] cand_idx;
    logic                  out_ready;
    logic                  ready_en;
    logic                  accept;
    logic                  sel_last;

    // While locked the grant ignores tvalid so tready never depends on the locked source.
    always_comb begin
        sel      = '0;
        have_sel = 1'b0;
        cand     = 0;
        cand_idx = '0;
        if (state_q == StLocked) begin
            sel      = lock_port_q;
            have_sel = 1'b1;
        end else begin
            for (int k = 1; k <= int'(NUM_PORTS); k++) begin
                cand = int'(last_grant_q) + k;
                if (cand >= int'(NUM_PORTS)) begin
                    cand = cand - int'(NUM_PORTS);
                end
                cand_idx = PORT_IDX_W'(cand);
                if (!have_sel && i_tx_tvalid[cand_idx]) begin
                    sel      = cand_idx;
                    have_sel = 1'b1;
                end
            end
        end
    end

    assign out_ready   = !tvalid_q || o_tx_tready;
    assign ready_en    = rst_n && out_ready && have_sel;
    assign i_tx_tready = ready_en ? (NUM_PORTS'(1) << sel) : '0;
    assign accept      = ready_en && i_tx_tvalid[sel];
    assign sel_last    = i_tx_tlast[sel];

    always_comb begin
        state_d      = state_q;
        lock_port_d  = lock_port_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            if (state_q == StUnlocked) begin
                last_grant_d = sel;
                if (!sel_last) begin
                    state_d     = StLocked;
                    lock_port_d = sel;
                end
            end else if (sel_last) begin
                state_d = StUnlocked;
            end
        end
    end

    always_comb begin
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tlast_d  = tlast_q;
        tuser_d  = tuser_q;
        if (out_ready) begin
            tvalid_d = accept;
        end
        if (accept) begin
            tdata_d = i_tx_tdata[sel*TDATA_W +: TDATA_W];
            tkeep_d = i_tx_tkeep[sel*KEEP_W +: KEEP_W];
            tlast_d = sel_last;
            tuser_d = i_tx_tuser_vendor[sel*TUSER_W +: TUSER_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StUnlocked;
            lock_port_q  <= '0;
            last_grant_q <= PORT_IDX_W'(NUM_PORTS - 1);
            tvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_port_q  <= lock_port_d;
            last_grant_q <= last_grant_d;
            tvalid_q     <= tvalid_d;
        end
    end

    // Payload is qualified by tvalid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        tdata_q <= tdata_d;
        tkeep_q <= tkeep_d;
        tlast_q <= tlast_d;
        tuser_q <= tuser_d;
    end

    assign o_tx_tvalid       = tvalid_q;
    assign o_tx_tdata        = tdata_q;
    assign o_tx_tkeep        = tkeep_q;
    assign o_tx_tlast        = tlast_q;
    assign o_tx_tuser_vendor = tuser_q;
    assign o_locked          = (state_q == StLocked);
    assign o_active_port     = (state_q == StLocked) ? lock_port_q : last_grant_q;

endmodule
